// File: rtl/branch_resolver.sv
// ID-stage branch resolver: hazard stall, condition evaluation,
// registered redirect pulse and saturating branch statistics.
module branch_resolver #(
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_wr_pending,
  input  logic [4:0]       mem_wr_addr,
  input  logic             mem_wr_pending,
  input  logic             flush,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_target,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_not_taken,
  output logic [CNT_W-1:0] cnt_stall,
  output logic             hold_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REDIR
  } state_t;

  state_t           r_state;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_target;
  logic [CNT_W-1:0] r_taken;
  logic [CNT_W-1:0] r_not_taken;
  logic [CNT_W-1:0] r_stall;
  logic [HW-1:0]    r_hold_cnt;
  logic             r_hold_err;

  logic          w_eff;
  logic          w_uses_rt;
  logic          w_dep_rs;
  logic          w_dep_rt;
  logic          w_hazard;
  logic          w_resolve;
  logic          w_cond;
  logic [31:0]   w_target;
  logic [HW-1:0] w_hold_base;
  logic [HW-1:0] w_hold_next;

  function automatic logic dep(input logic [4:0] r);
    return (r != 5'd0) &&
           ((ex_wr_pending && ex_wr_addr == r) ||
            (mem_wr_pending && mem_wr_addr == r));
  endfunction

  assign w_eff     = br_valid && br_type != 3'd0 && br_type != 3'd7;
  assign w_uses_rt = br_type == 3'd1 || br_type == 3'd6;
  assign w_dep_rs  = dep(rs_addr);
  assign w_dep_rt  = dep(rt_addr);
  assign w_hazard  = w_eff && (w_dep_rs || (w_uses_rt && w_dep_rt));
  assign w_resolve = w_eff && !w_hazard && !flush;
  assign stall_id  = w_hazard && !flush && reset;

  assign w_target = br_pc + 32'd4 +
                    {{14{br_imm[15]}}, br_imm, 2'b00};

  always_comb begin
    w_cond = 1'b0;
    case (br_type)
      3'd1:    w_cond = rs_val == rt_val;
      3'd2:    w_cond = $signed(rs_val) >  32'sd0;
      3'd3:    w_cond = $signed(rs_val) <= 32'sd0;
      3'd4:    w_cond = $signed(rs_val) >= 32'sd0;
      3'd5:    w_cond = $signed(rs_val) <  32'sd0;
      3'd6:    w_cond = rs_val != rt_val;
      default: w_cond = 1'b0;
    endcase
  end

  // Stall count restarts whenever a branch first enters HOLD
  assign w_hold_base = (r_state == HOLD) ? r_hold_cnt : '0;
  assign w_hold_next = (w_hold_base == HW'(MAX_HOLD)) ?
                       w_hold_base : w_hold_base + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
      r_taken           <= '0;
      r_not_taken       <= '0;
      r_stall           <= '0;
      r_hold_cnt        <= '0;
      r_hold_err        <= 1'b0;
    end else begin
      r_redirect_valid <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else if (w_hazard) begin
        r_state    <= HOLD;
        r_hold_cnt <= w_hold_next;
        if (w_hold_next == HW'(MAX_HOLD))
          r_hold_err <= 1'b1;
        if (r_stall != '1)
          r_stall <= r_stall + 1'b1;
      end else if (w_resolve && w_cond) begin
        r_state           <= REDIR;
        r_redirect_valid  <= 1'b1;
        r_redirect_target <= w_target;
        if (r_taken != '1)
          r_taken <= r_taken + 1'b1;
      end else if (w_resolve) begin
        r_state <= IDLE;
        if (r_not_taken != '1)
          r_not_taken <= r_not_taken + 1'b1;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign redirect_valid  = r_redirect_valid;
  assign redirect_target = r_redirect_target;
  assign cnt_taken       = r_taken;
  assign cnt_not_taken   = r_not_taken;
  assign cnt_stall       = r_stall;
  assign hold_err        = r_hold_err;

endmodule
